// File: rtl/fifo_port_arbiter.sv
// rtl/fifo_port_arbiter.sv - round-robin write/read arbiter for a FIFO backed by a single-port RAM
module fifo_port_arbiter #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
        WR_REJECT,
        RD_REJECT
    } state_t;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          last_grant_q, last_grant_d;
    logic          wr_elig, rd_elig;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            last_grant_q <= GRANT_RD;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign wr_elig = wr_req && !full;
    assign rd_elig = rd_req && !empty;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time is granted.
                if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
                    state_d      = WRITE;
                    last_grant_d = GRANT_WR;
                end else if (rd_elig) begin
                    state_d      = READ;
                    last_grant_d = GRANT_RD;
                end else if (wr_req) begin
                    state_d = WR_REJECT;
                end else if (rd_req) begin
                    state_d = RD_REJECT;
                end
            end
            WRITE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
                state_d  = IDLE;
            end
            READ: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
                state_d  = READ_WAIT;
            end
            READ_WAIT: begin
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        case (state_q)
            WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = rd_ptr_q;
                rd_ack   = 1'b1;
            end
            WR_REJECT: begin
                wr_ack   = 1'b1;
                overflow = 1'b1;
            end
            RD_REJECT: begin
                rd_ack    = 1'b1;
                underflow = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb/tb_fifo_port_arbiter.sv - scoreboard bench for fifo_port_arbiter with a behavioural single-port RAM
module tb_fifo_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, rd_req;
    logic [7:0] wr_data;
    logic       wr_ack, rd_ack, rd_valid;
    logic [7:0] rd_data;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [4:0] count;
    logic       full, empty, overflow, underflow;

    logic [7:0] ram [16];
    logic [7:0] exp_q [$];
    int pass_cnt = 0;
    int total_cnt = 0;

    fifo_port_arbiter #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic do_write(input logic [7:0] d, output int lat, output logic ovf,
                            output logic men, output logic mwe, output logic [3:0] maddr,
                            output logic [7:0] mwd);
        wr_req = 1'b1; wr_data = d;
        lat = 0; ovf = 1'b0; men = 1'b0; mwe = 1'b0; maddr = '0; mwd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                lat = i; ovf = overflow; men = mem_en; mwe = mem_we; maddr = mem_addr; mwd = mem_wdata;
                break;
            end
        end
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(output int lat, output logic unf, output logic men,
                           output logic [3:0] maddr, output int vlat, output logic [7:0] d);
        rd_req = 1'b1;
        lat = 0; unf = 1'b0; men = 1'b0; maddr = '0; vlat = 0; d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                lat = i; unf = underflow; men = mem_en; maddr = mem_addr;
                break;
            end
        end
        rd_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                vlat = i; d = rd_data;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if ({empty, full} !== 2'b10) $display("FAIL reset_flags: got empty=%b full=%b exp 1 0", empty, full); else pass_cnt++;
        total_cnt++;
        if ({wr_ack, rd_ack, rd_valid, mem_en, overflow, underflow} !== 6'b0)
            $display("FAIL reset_strobes: got %b exp 000000", {wr_ack, rd_ack, rd_valid, mem_en, overflow, underflow});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        int acks;
        wr_req = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        total_cnt++; if (wr_ack !== 1'b1) $display("FAIL midwr_ack_seen: got %b exp 1", wr_ack); else pass_cnt++;
        reset = 1'b1; wr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (count !== 5'd0) $display("FAIL midwr_count: got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL midwr_empty: got %b exp 1", empty); else pass_cnt++;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_ack) acks++;
        end
        total_cnt++; if (acks != 0) $display("FAIL midwr_no_ack: got %0d acks exp 0", acks); else pass_cnt++;
    endtask

    task automatic test_single();
        int lat, vlat; logic ovf, men, mwe, unf; logic [3:0] ma; logic [7:0] wd, d, e;
        total_cnt++; if (count !== 5'd0) $display("FAIL single_count0: got %0d exp 0", count); else pass_cnt++;
        exp_q.push_back(8'hA5);
        do_write(8'hA5, lat, ovf, men, mwe, ma, wd);
        total_cnt++; if (lat != 1) $display("FAIL single_wr_lat: got %0d exp 1", lat); else pass_cnt++;
        total_cnt++;
        if ({men, mwe, ovf, ma, wd} !== {1'b1, 1'b1, 1'b0, 4'd0, 8'hA5})
            $display("FAIL single_wr_mem: got en=%b we=%b ovf=%b addr=%0d wdata=%h exp 1 1 0 0 a5", men, mwe, ovf, ma, wd);
        else pass_cnt++;
        total_cnt++; if (count !== 5'd1) $display("FAIL single_count1: got %0d exp 1", count); else pass_cnt++;
        do_read(lat, unf, men, ma, vlat, d);
        e = exp_q.pop_front();
        total_cnt++; if (lat != 1 || unf !== 1'b0 || men !== 1'b1 || ma !== 4'd0)
            $display("FAIL single_rd_ack: got lat=%0d unf=%b en=%b addr=%0d exp 1 0 1 0", lat, unf, men, ma);
        else pass_cnt++;
        total_cnt++; if (vlat != 2) $display("FAIL single_rd_valid_lat: got %0d exp 2", vlat); else pass_cnt++;
        total_cnt++; if (d !== e) $display("FAIL single_rd_data: got %h exp %h", d, e); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL single_count_end: got %0d exp 0", count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat, vlat; logic ovf, men, mwe, unf; logic [3:0] ma; logic [7:0] wd, d, e;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            do_write(8'(i), lat, ovf, men, mwe, ma, wd);
        end
        total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count_full: got %0d exp 16", count); else pass_cnt++;
        total_cnt++; if ({full, empty} !== 2'b10) $display("FAIL ovf_flags: got full=%b empty=%b exp 1 0", full, empty); else pass_cnt++;
        do_write(8'hFF, lat, ovf, men, mwe, ma, wd);
        total_cnt++; if (lat != 1 || ovf !== 1'b1 || men !== 1'b0)
            $display("FAIL ovf_reject: got lat=%0d overflow=%b mem_en=%b exp 1 1 0", lat, ovf, men);
        else pass_cnt++;
        total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count_held: got %0d exp 16", count); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            do_read(lat, unf, men, ma, vlat, d);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            total_cnt++; if (vlat != 2 || d !== e) $display("FAIL ovf_drain_%0d: got data=%h vlat=%0d exp %h 2", i, d, vlat, e); else pass_cnt++;
        end
        total_cnt++; if (empty !== 1'b1) $display("FAIL ovf_empty_end: got %b exp 1", empty); else pass_cnt++;
    endtask

    task automatic test_underflow();
        int lat, vlat; logic unf, men; logic [3:0] ma; logic [7:0] d;
        do_read(lat, unf, men, ma, vlat, d);
        total_cnt++; if (lat != 1 || unf !== 1'b1 || men !== 1'b0)
            $display("FAIL unf_reject: got lat=%0d underflow=%b mem_en=%b exp 1 1 0", lat, unf, men);
        else pass_cnt++;
        total_cnt++; if (vlat != 0) $display("FAIL unf_no_valid: got rd_valid after %0d cycles exp none", vlat); else pass_cnt++;
        total_cnt++; if (count !== 5'd0) $display("FAIL unf_count: got %0d exp 0", count); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int lat, vlat, ng, nv; logic ovf, men, mwe, unf, pend; logic [3:0] ma; logic [7:0] wd, d, e;
        logic [3:0] grants; logic [4:0] cnts [4];
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            do_write(8'h10 + 8'(i), lat, ovf, men, mwe, ma, wd);
        end
        do_read(lat, unf, men, ma, vlat, d);
        e = exp_q.pop_front();
        total_cnt++; if (d !== e || count !== 5'd4) $display("FAIL rr_setup: got data=%h count=%0d exp %h 4", d, count, e); else pass_cnt++;
        grants = '0; ng = 0; nv = 0; pend = 1'b0;
        for (int i = 0; i < 4; i++) cnts[i] = '0;
        wr_data = 8'h20; wr_req = 1'b1; rd_req = 1'b1;
        for (int cyc = 0; cyc < 40 && (ng < 4 || pend || nv < 2); cyc++) begin
            @(negedge clk);
            if (pend) begin
                cnts[ng-1] = count; pend = 1'b0;
                if (ng >= 4) begin wr_req = 1'b0; rd_req = 1'b0; end
            end
            if (rd_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                total_cnt++; if (rd_data !== e) $display("FAIL rr_rd_data_%0d: got %h exp %h", nv, rd_data, e); else pass_cnt++;
                nv++;
            end
            if ((wr_ack || rd_ack) && ng < 4) begin
                grants[3-ng] = wr_ack;
                ng++; pend = 1'b1;
                if (wr_ack) begin exp_q.push_back(wr_data); wr_data = wr_data + 8'd1; end
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        total_cnt++; if (grants !== 4'b1010 || ng != 4) $display("FAIL rr_order: got %b (%0d grants) exp 1010 (W=1)", grants, ng); else pass_cnt++;
        total_cnt++;
        if ({cnts[0], cnts[1], cnts[2], cnts[3]} !== {5'd5, 5'd4, 5'd5, 5'd4})
            $display("FAIL rr_counts: got %0d %0d %0d %0d exp 5 4 5 4", cnts[0], cnts[1], cnts[2], cnts[3]);
        else pass_cnt++;
        total_cnt++; if (nv != 2) $display("FAIL rr_valid_count: got %0d exp 2", nv); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int lat, vlat; logic ovf, men, mwe, unf; logic [3:0] ma; logic [7:0] wd, d, e;
        @(negedge clk);
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(i));
            do_write(8'(i), lat, ovf, men, mwe, ma, wd);
            total_cnt++; if (ma !== 4'(i % 16) || mwe !== 1'b1) $display("FAIL wrap_wr_addr_%0d: got %0d we=%b exp %0d 1", i, ma, mwe, i % 16); else pass_cnt++;
            do_read(lat, unf, men, ma, vlat, d);
            e = exp_q.pop_front();
            total_cnt++; if (ma !== 4'(i % 16) || d !== e) $display("FAIL wrap_rd_%0d: got addr=%0d data=%h exp %0d %h", i, ma, d, i % 16, e); else pass_cnt++;
        end
        total_cnt++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL wrap_empty_end: got empty=%b count=%0d exp 1 0", empty, count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_single();
        test_overflow();
        test_underflow();
        test_round_robin();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of FIFO entries (power of two).
REQ-002 The block SHALL have parameter AW, default 4, giving the address width, log2(DEPTH).
REQ-003 The block SHALL have parameter DW, default 8, giving the data width.
REQ-004 The block SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-006 The block SHALL have port wr_req, input, 1, write request, held high until wr_ack.
REQ-007 The block SHALL have port wr_data, input, DW, write data, stable while wr_req is high.
REQ-008 The block SHALL have port wr_ack, output, 1, one-cycle write completion or rejection.
REQ-009 The block SHALL have port rd_req, input, 1, read request, held high until rd_ack.
REQ-010 The block SHALL have port rd_ack, output, 1, one-cycle read acceptance or rejection.
REQ-011 The block SHALL have port rd_valid, output, 1, one-cycle strobe qualifying rd_data.
REQ-012 The block SHALL have port rd_data, output, DW, registered read data.
REQ-013 The block SHALL have port mem_en, output, 1, single-port RAM enable.
REQ-014 The block SHALL have port mem_we, output, 1, RAM write enable.
REQ-015 The block SHALL have port mem_addr, output, AW, RAM address.
REQ-016 The block SHALL have port mem_wdata, output, DW, RAM write data.
REQ-017 The block SHALL have port mem_rdata, input, DW, RAM read data, valid one cycle after a read-enabled cycle.
REQ-018 The block SHALL have port count, output, AW+1, current occupancy, 0..DEPTH.
REQ-019 The block SHALL have ports full and empty, output, 1 each, asserted at count==DEPTH and count==0 respectively.
REQ-020 The block SHALL have ports overflow and underflow, output, 1 each, one-cycle rejection flags.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE, READ, READ_WAIT, WR_REJECT and RD_REJECT; only IDLE samples requests.
REQ-022 A write SHALL be eligible when wr_req=1 and full=0; a read SHALL be eligible when rd_req=1 and empty=0.
REQ-023 In IDLE with exactly one eligible request, that request SHALL be granted: next state WRITE or READ.
REQ-024 In IDLE with both eligible, the side opposite last_grant SHALL be granted, and last_grant SHALL be updated on every grant (round-robin).
REQ-025 In IDLE with no eligible request, the following SHALL apply: wr_req with full goes to WR_REJECT; otherwise rd_req with empty goes to RD_REJECT; otherwise the FSM stays in IDLE.
REQ-026 In WRITE (one cycle), the outputs SHALL be mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=wr_data and wr_ack=1; at cycle end wr_ptr+1 and count+1; next state IDLE.
REQ-027 In READ (one cycle), the outputs SHALL be mem_en=1, mem_we=0, mem_addr=rd_ptr and rd_ack=1; at cycle end rd_ptr+1 and count-1; next state READ_WAIT.
REQ-028 In READ_WAIT, rd_data SHALL capture mem_rdata at cycle end; rd_valid SHALL be 1 for exactly the following cycle; next state IDLE.
REQ-029 In WR_REJECT, the outputs SHALL be wr_ack=1 and overflow=1 with no RAM access and no pointer or count change; the data is discarded; next state IDLE.
REQ-030 In RD_REJECT, the outputs SHALL be rd_ack=1 and underflow=1 with no RAM access, no rd_valid and no change; next state IDLE.
REQ-031 mem_*, wr_ack, rd_ack, overflow and underflow SHALL be decoded from the state register only, and SHALL be 0 in all other states.
REQ-032 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0); count SHALL never exceed DEPTH or go below 0.
REQ-033 Latency SHALL be: request seen in IDLE at cycle N -> ack at N+1; read data on rd_valid at N+3; maximum throughput is one write per 2 cycles and one read per 3 cycles.
REQ-034 A request still high in the IDLE cycle after its ack SHALL be treated as a new request; requesters deassert the cycle after ack.
REQ-035 full, empty and count SHALL be combinational from the count register.

Reset
REQ-036 While reset=1 at a clock edge, the block SHALL set state IDLE, wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0 and last_grant=READ (so writes win the first tie).
REQ-037 Reset SHALL take priority over all updates: if reset is asserted during WRITE or READ, pointers and count SHALL NOT update, no subsequent ack or rd_valid SHALL be issued, and the state-decoded outputs of that cycle still appear.
REQ-038 After reset, the outputs SHALL be empty=1, full=0, count=0, and all strobes 0.

Verification
REQ-039 Reset check: hold reset 2 cycles mid-write -> count=0, empty=1, no wr_ack after release.
REQ-040 Single transfer: write 0xA5, then read -> wr_ack at N+1, mem_addr=0, mem_we=1; rd_ack, then rd_valid with rd_data=0xA5; count 0->1->0.
REQ-041 Overflow: 16 writes (0x00..0x0F), then a 17th write 0xFF -> full=1, count=16, wr_ack with overflow=1, no mem_en; 16 reads return 0x00..0x0F.
REQ-042 Underflow: rd_req while empty -> rd_ack and underflow=1 one cycle later, rd_valid stays 0, count stays 0.
REQ-043 Round-robin: count=4 with wr_req and rd_req held continuously -> grant order W,R,W,R; count alternates 5,4,5,4.
REQ-044 Wrap-around: 40 alternating write/read pairs with data i -> addresses cycle 0..15 then 0, each rd_data=i, empty=1 at end.
